// File: rtl/ecc_pkg.sv
// Shared field-arithmetic definitions for the ECC datapath blocks.
package ecc_pkg;

  localparam int unsigned WIDTH = 256;

  // Default field prime: 2^256 - 2^32 - 977
  localparam logic [WIDTH-1:0] P_DEFAULT =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [2:0] {
    INV_IDLE,
    INV_LOAD,
    INV_SQ_ISSUE,
    INV_SQ_WAIT,
    INV_MUL_ISSUE,
    INV_MUL_WAIT,
    INV_NEXT,
    INV_FINISH
  } inv_state_e;

endpackage

// File: rtl/mod_inverse_multiplier.sv
// Modular multiplier: product = a*b mod P using MSB-first interleaved
// shift-add, DIGIT bits of b per clock. Operands are captured while Reset
// is high; Done rises WIDTH/DIGIT cycles after Reset is released and holds.
module multiplier
  import ecc_pkg::*;
#(
  parameter logic [WIDTH-1:0] P     = P_DEFAULT,
  parameter int unsigned      DIGIT = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             Done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [WIDTH-1:0] a_q, b_q, b_d, r_q, r_d;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  // One digit step: per bit r = 2r (+a if bit set), each partial kept below P.
  always_comb begin
    logic [WIDTH:0] t;
    r_d = r_q;
    b_d = b_q;
    t   = '0;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      t = {r_d, 1'b0};
      if (t >= {1'b0, P}) t = t - {1'b0, P};
      if (b_d[WIDTH-1]) begin
        t = t + {1'b0, a_q};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
      end
      r_d = t[WIDTH-1:0];
      b_d = {b_d[WIDTH-2:0], 1'b0};
    end
  end

  // Reset is a combinational clear from the sequencer, so it is applied synchronously.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q    <= a;
      b_q    <= b;
      r_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      r_q   <= r_d;
      b_q   <= b_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(NDIG - 1)) done_q <= 1'b1;
    end
  end

  assign Done    = done_q;
  assign product = r_q;

endmodule

// File: rtl/mod_inverse.sv
// Modular inverse a^(P-2) mod P by left-to-right square-and-multiply over
// a single shared multiplier, with a Start/Done handshake.
module mod_inverse
  import ecc_pkg::*;
#(
  parameter logic [WIDTH-1:0] P         = P_DEFAULT,
  parameter int unsigned      MUL_DIGIT = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out,
  output logic             Done,
  output logic             Busy,
  output logic             Error
);

  localparam logic [WIDTH-1:0] E = P - WIDTH'(2);

  inv_state_e       state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       idx_q, idx_d;
  logic             err_q, err_d;

  logic             mul_clear;
  logic             mul_rst;
  logic             mul_done;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_product;

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= INV_IDLE;
      base_q  <= '0;
      acc_q   <= '0;
      idx_q   <= 8'd255;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Sequencer: next state, datapath updates and multiplier clear.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    err_d     = err_q;
    mul_clear = 1'b0;
    unique case (state_q)
      INV_IDLE, INV_FINISH: begin
        if (Start) begin
          base_d  = a;
          acc_d   = WIDTH'(1);
          idx_d   = 8'd255;
          err_d   = (a == '0) || (a >= P);
          state_d = INV_LOAD;
        end
      end
      INV_LOAD:      state_d = err_q ? INV_FINISH : INV_SQ_ISSUE;
      INV_SQ_ISSUE: begin
        mul_clear = 1'b1;
        state_d   = INV_SQ_WAIT;
      end
      INV_SQ_WAIT: begin
        if (mul_done) begin
          acc_d   = mul_product;
          state_d = E[idx_q] ? INV_MUL_ISSUE : INV_NEXT;
        end
      end
      INV_MUL_ISSUE: begin
        mul_clear = 1'b1;
        state_d   = INV_MUL_WAIT;
      end
      INV_MUL_WAIT: begin
        if (mul_done) begin
          acc_d   = mul_product;
          state_d = INV_NEXT;
        end
      end
      INV_NEXT: begin
        if (idx_q == 8'd0) begin
          state_d = INV_FINISH;
        end else begin
          idx_d   = idx_q - 8'd1;
          state_d = INV_SQ_ISSUE;
        end
      end
      default:       state_d = INV_IDLE;
    endcase
  end

  // The multiplier latches its operands during the issue-cycle clear, so
  // the b-operand mux only needs to select base in Mul_issue.
  assign mul_b   = (state_q == INV_MUL_ISSUE) ? base_q : acc_q;
  assign mul_rst = ~Reset_n | mul_clear;

  multiplier #(
    .P     (P),
    .DIGIT (MUL_DIGIT)
  ) u_mul (
    .Clk     (Clk),
    .Reset   (mul_rst),
    .a       (acc_q),
    .b       (mul_b),
    .Done    (mul_done),
    .product (mul_product)
  );

  assign Done  = (state_q == INV_FINISH);
  assign Error = Done & err_q;
  assign Busy  = (state_q != INV_IDLE) && (state_q != INV_FINISH);
  assign out   = (Done && !err_q) ? acc_q : '0;

endmodule

// File: tb/tb_mod_inverse.sv
// Randomized self-checking bench for mod_inverse.
module tb_mod_inverse;
  import ecc_pkg::*;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int unsigned BUDGET = 4000;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [255:0] a_in = '0;
  logic [255:0] out;
  logic         Done, Busy, Error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mod_inverse #(
    .P         (P),
    .MUL_DIGIT (256)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .a       (a_in),
    .out     (out),
    .Done    (Done),
    .Busy    (Busy),
    .Error   (Error)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: (x*y) mod P with plain wide arithmetic.
  function automatic logic [255:0] ref_mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] pr;
    pr = {256'b0, x} * {256'b0, y};
    pr = pr % {256'b0, P};
    return pr[255:0];
  endfunction

  function automatic int unsigned popcount_e();
    logic [255:0] e;
    int unsigned  c;
    e = P - 256'd2;
    c = 0;
    for (int i = 0; i < 256; i++) c += e[i];
    return c;
  endfunction

  function automatic logic [255:0] rand_operand();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return (r % (P - 256'd1)) + 256'd1;
  endfunction

  // Present Start for one cycle; returns just after the accepting edge.
  task automatic start_op(input logic [255:0] val);
    @(negedge Clk);
    a_in  = val;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    a_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts edges after acceptance until Done; also measures M on the first multiply.
  task automatic wait_done(output int unsigned n, output int unsigned m);
    bit in_mul, m_done;
    n = 0; m = 0; in_mul = 0; m_done = 0;
    while (n < BUDGET && !Done) begin
      @(posedge Clk);
      #1;
      n++;
      if (!m_done) begin
        if (in_mul) begin
          m++;
          if (dut.mul_done) m_done = 1;
        end else if (dut.mul_rst) begin
          in_mul = 1;
        end
      end
    end
    check_val("done_seen", Done, 1'b1);
  endtask

  task automatic run_inv(input logic [255:0] val, output logic [255:0] r,
                         output logic err, output int unsigned n, output int unsigned m);
    start_op(val);
    wait_done(n, m);
    r   = out;
    err = Error;
  endtask

  task automatic check_inverse(input string tag, input logic [255:0] val);
    logic [255:0] r;
    logic         e;
    int unsigned  n, m;
    run_inv(val, r, e, n, m);
    check_val({tag, "_prod"}, ref_mulmod(val, r), 256'd1);
    check_val({tag, "_range"}, r < P, 1'b1);
    check_val({tag, "_err"}, e, 1'b0);
  endtask

  initial begin
    logic [255:0] r, v;
    logic         e;
    int unsigned  n, m, w, bound;

    #22;
    check_val("rst_out", out, '0);
    check_val("rst_flags", {Done, Busy, Error}, 3'b000);
    @(negedge Clk);
    Reset_n = 1'b1;

    // a = 1: value and latency
    w = popcount_e();
    run_inv(256'd1, r, e, n, m);
    check_val("a1_out", r, 256'd1);
    check_val("a1_err", e, 1'b0);
    check_val("a1_lat", n, 1 + 256 * (m + 2) + w * (m + 1));

    run_inv(256'd2, r, e, n, m);
    check_val("a2_out", r, (P + 256'd1) >> 1);

    run_inv(P - 256'd1, r, e, n, m);
    check_val("apm1_out", r, P - 256'd1);

    for (int i = 0; i < 20; i++) begin
      v = rand_operand();
      check_inverse("rand", v);
    end

    // Invalid operands: Done after 2 cycles counting the Start cycle
    run_inv(256'd0, r, e, n, m);
    check_val("a0_lat", n + 1, 2);
    check_val("a0_err", e, 1'b1);
    check_val("a0_out", r, '0);
    run_inv(P, r, e, n, m);
    check_val("aP_lat", n + 1, 2);
    check_val("aP_err", e, 1'b1);
    check_val("aP_out", r, '0);
    check_inverse("a3_after_err", 256'd3);

    // Reset in the middle of Mul_wait
    start_op(256'd5);
    bound = 0;
    while (bound < BUDGET && dut.state_q != INV_MUL_WAIT) begin
      @(posedge Clk);
      #1;
      bound++;
    end
    check_val("reach_mul_wait", dut.state_q == INV_MUL_WAIT, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("abort_out", out, '0);
    check_val("abort_flags", {Done, Busy, Error}, 3'b000);
    @(negedge Clk);
    Reset_n = 1'b1;
    check_inverse("a5_after_rst", 256'd5);

    // Start while Busy is ignored
    start_op(256'd3);
    repeat (5) @(negedge Clk);
    check_val("busy_mid", Busy, 1'b1);
    a_in  = 256'd7;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(n, m);
    check_val("ignored_prod", ref_mulmod(256'd3, out), 256'd1);
    check_val("ignored_err", Error, 1'b0);

    // Start from Finish restarts directly
    start_op(256'd7);
    check_val("restart_done_drop", Done, 1'b0);
    check_val("restart_busy", Busy, 1'b1);
    wait_done(n, m);
    check_val("restart_prod", ref_mulmod(256'd7, out), 256'd1);
    check_val("restart_err", Error, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
